// File: rtl/fx_ga_pkg.sv
// ---------------------------------------------------------------------------
// fx_ga_pkg
// Shared definitions for the PC-FX gate array blocks.
//   - TMC register select encodings ({A7,A6})
//   - TMC CTRL register bit positions
//   - tmc_ctrl_t: packed CTRL register image (ST at bit 2, IE at 1, EN at 0)
//   - tmc_eff_period: maps a programmed PERIOD to the 17-bit reload value
// ---------------------------------------------------------------------------
package fx_ga_pkg;

    localparam logic [1:0] TMC_REG_CTRL    = 2'b00;
    localparam logic [1:0] TMC_REG_PERIOD  = 2'b10;
    localparam logic [1:0] TMC_REG_COUNTER = 2'b11;

    localparam int TMC_EN = 0;
    localparam int TMC_IE = 1;
    localparam int TMC_ST = 2;

    typedef struct packed {
        logic st;
        logic ie;
        logic en;
    } tmc_ctrl_t;

    // A programmed period of 0 stands for a full 65536-count interval, which
    // is why the counter needs a 17th bit.
    function automatic logic [16:0] tmc_eff_period(input logic [15:0] period);
        return (period == 16'd0) ? 17'h1_0000 : {1'b0, period};
    endfunction

endpackage

// File: rtl/fx_ga_tmc.sv
// ---------------------------------------------------------------------------
// fx_ga_tmc
// PC-FX gate array Timer Control unit. A 16-bit auto-reloading down-counter
// behind a fixed CE prescaler; each expiry sets a sticky ST flag, and
// INT = ST & IE feeds INTTM (ISR bit 6) of the interrupt controller.
//
// Ports:
//   CLK    in   system clock
//   RESn   in   asynchronous active-low reset
//   CE     in   clock enable; state only advances when high
//   CSn    in   chip select for the 0xF00..0xFFF window (active-low)
//   A7,A6  in   register select: 00 CTRL, 10 PERIOD, 11 COUNTER, 01 unused
//   RDn    in   read strobe (active-low)
//   WRn    in   write strobe (active-low, level-sensitive)
//   DI     in   write data [15:0]
//   DO     out  read data [15:0], zero unless CSn=0 and RDn=0
//   INT    out  interrupt request (active-high)
// ---------------------------------------------------------------------------
module fx_ga_tmc
    import fx_ga_pkg::*;
#(
    parameter int PRESCALE = 15
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        CSn,
    input  logic        A7,
    input  logic        A6,
    input  logic        RDn,
    input  logic        WRn,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        INT
);

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    logic [1:0]  sel;
    tmc_ctrl_t   ctrl;
    logic [15:0] period;
    logic [16:0] counter;
    logic [7:0]  prescaler;

    logic        wr_ctrl;
    logic        wr_period;
    tmc_ctrl_t   ctrl_next;
    logic [15:0] period_next;
    logic [16:0] counter_next;
    logic [7:0]  prescaler_next;
    logic        start;
    logic        running;
    logic        ps_wrap;
    logic        expire;

    assign sel = {A7, A6};

    // Next-state logic. Bus writes are folded in first so that a write of
    // EN=0 suppresses counting in the same cycle, and an enabling write sees
    // a PERIOD written alongside it. Expiry setting ST is applied after a
    // write clearing ST, so a coincident expiry wins.
    always_comb begin
        wr_ctrl        = !CSn && !WRn && (sel == TMC_REG_CTRL);
        wr_period      = !CSn && !WRn && (sel == TMC_REG_PERIOD);

        period_next    = wr_period ? DI : period;

        ctrl_next      = ctrl;
        if (wr_ctrl) begin
            ctrl_next.en = DI[TMC_EN];
            ctrl_next.ie = DI[TMC_IE];
            if (!DI[TMC_ST]) begin
                ctrl_next.st = 1'b0;
            end
        end

        start          = ctrl_next.en && !ctrl.en;
        running        = ctrl_next.en && ctrl.en;
        ps_wrap        = running && (prescaler == PS_LAST);
        expire         = ps_wrap && (counter == 17'd1);

        counter_next   = counter;
        prescaler_next = prescaler;
        if (start) begin
            counter_next   = tmc_eff_period(period_next);
            prescaler_next = 8'd0;
        end else if (running) begin
            if (ps_wrap) begin
                prescaler_next = 8'd0;
                counter_next   = expire ? tmc_eff_period(period_next)
                                        : counter - 17'd1;
            end else begin
                prescaler_next = prescaler + 8'd1;
            end
        end

        if (expire) begin
            ctrl_next.st = 1'b1;
        end
    end

    // All timer state; reset is asynchronous and ignores CE.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            ctrl      <= '0;
            period    <= '0;
            counter   <= '0;
            prescaler <= '0;
        end else if (CE) begin
            ctrl      <= ctrl_next;
            period    <= period_next;
            counter   <= counter_next;
            prescaler <= prescaler_next;
        end
    end

    // Read mux; the bus sees zero whenever the window is not being read.
    always_comb begin
        DO = 16'd0;
        if (!CSn && !RDn) begin
            case (sel)
                TMC_REG_CTRL:    DO = {13'd0, ctrl};
                TMC_REG_PERIOD:  DO = period;
                TMC_REG_COUNTER: DO = counter[15:0];
                default:         DO = 16'd0;
            endcase
        end
    end

    assign INT = ctrl.st & ctrl.ie;

endmodule

// File: tb/tb_fx_ga_tmc.sv
// ---------------------------------------------------------------------------
// tb_fx_ga_tmc
// Directed bench for fx_ga_tmc. Instance dut0 uses PRESCALE=15 and carries
// the register, expiry, simultaneous-event, CE-duty and reset sequences;
// instance dut1 uses PRESCALE=1 for the full 65536-count PERIOD=0 interval.
// Both share the bus; separate chip selects keep them independent.
// ---------------------------------------------------------------------------
module tb_fx_ga_tmc;

    localparam logic [1:0] R_CTRL = 2'b00;
    localparam logic [1:0] R_NONE = 2'b01;
    localparam logic [1:0] R_PER  = 2'b10;
    localparam logic [1:0] R_CNT  = 2'b11;

    logic        CLK;
    logic        RESn;
    logic        CE;
    logic        CSn0;
    logic        CSn1;
    logic        A7;
    logic        A6;
    logic        RDn;
    logic        WRn;
    logic [15:0] DI;
    logic [15:0] DO0;
    logic [15:0] DO1;
    logic        INT0;
    logic        INT1;

    int checks   = 0;
    int failures = 0;

    fx_ga_tmc #(.PRESCALE(15)) dut0 (
        .CLK (CLK),
        .RESn(RESn),
        .CE  (CE),
        .CSn (CSn0),
        .A7  (A7),
        .A6  (A6),
        .RDn (RDn),
        .WRn (WRn),
        .DI  (DI),
        .DO  (DO0),
        .INT (INT0)
    );

    fx_ga_tmc #(.PRESCALE(1)) dut1 (
        .CLK (CLK),
        .RESn(RESn),
        .CE  (CE),
        .CSn (CSn1),
        .A7  (A7),
        .A6  (A6),
        .RDn (RDn),
        .WRn (WRn),
        .DI  (DI),
        .DO  (DO1),
        .INT (INT1)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Guard against a runaway run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        do_write;
        logic [1:0]  wr_sel;
        logic [15:0] wr_data;
        logic        do_read;
        logic [1:0]  rd_sel;
        logic [15:0] exp_do;
        logic        exp_int;
    } vec_t;

    vec_t vectors[8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One-cycle bus write to the selected instance.
    task automatic applyStimulus(input int dev, input logic [1:0] sel, input logic [15:0] data);
        {A7, A6} = sel;
        DI       = data;
        WRn      = 1'b0;
        if (dev == 0) CSn0 = 1'b0;
        else          CSn1 = 1'b0;
        tick();
        WRn  = 1'b1;
        CSn0 = 1'b1;
        CSn1 = 1'b1;
    endtask

    task automatic read_reg(input int dev, input logic [1:0] sel, input logic cs_active,
                            output logic [15:0] val);
        {A7, A6} = sel;
        RDn      = 1'b0;
        if (cs_active) begin
            if (dev == 0) CSn0 = 1'b0;
            else          CSn1 = 1'b0;
        end
        #1;
        val  = (dev == 0) ? DO0 : DO1;
        RDn  = 1'b1;
        CSn0 = 1'b1;
        CSn1 = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reg(input int dev, input logic [1:0] sel, input logic [15:0] exp,
                             input string name);
        logic [15:0] v;
        read_reg(dev, sel, 1'b1, v);
        checkOutput(name, {16'd0, v}, {16'd0, exp});
    endtask

    task automatic check_int(input int dev, input logic exp, input string name);
        logic v;
        v = (dev == 0) ? INT0 : INT1;
        checkOutput(name, {31'd0, v}, {31'd0, exp});
    endtask

    initial begin
        logic [15:0] rv;

        // Register access table for dut0 while the timer is stopped.
        vectors[0] = '{1'b1, R_PER,  16'h1234, 1'b1, R_PER,  16'h1234, 1'b0};
        vectors[1] = '{1'b1, R_CTRL, 16'hFFFA, 1'b1, R_CTRL, 16'h0002, 1'b0};
        vectors[2] = '{1'b1, R_NONE, 16'hFFFF, 1'b1, R_PER,  16'h1234, 1'b0};
        vectors[3] = '{1'b1, R_CNT,  16'h5555, 1'b1, R_CNT,  16'h0000, 1'b0};
        vectors[4] = '{1'b0, R_CTRL, 16'h0000, 1'b1, R_NONE, 16'h0000, 1'b0};
        vectors[5] = '{1'b1, R_PER,  16'hBEEF, 1'b0, R_PER,  16'h0000, 1'b0};
        vectors[6] = '{1'b0, R_CTRL, 16'h0000, 1'b1, R_PER,  16'hBEEF, 1'b0};
        vectors[7] = '{1'b1, R_CTRL, 16'h0000, 1'b1, R_CTRL, 16'h0000, 1'b0};

        RESn = 1'b0;
        CE   = 1'b1;
        CSn0 = 1'b1;
        CSn1 = 1'b1;
        A7   = 1'b0;
        A6   = 1'b0;
        RDn  = 1'b1;
        WRn  = 1'b1;
        DI   = 16'd0;

        ticks(3);
        RESn = 1'b1;
        ticks(2);
        $display("[TB] reset state");
        check_reg(0, R_CTRL, 16'h0000, "rst_ctrl");
        check_reg(0, R_PER,  16'h0000, "rst_period");
        check_reg(0, R_CNT,  16'h0000, "rst_counter");
        check_int(0, 1'b0, "rst_int");
        check_reg(1, R_CTRL, 16'h0000, "rst_ctrl_dut1");

        $display("[TB] register table");
        for (int i = 0; i < 8; i++) begin
            if (vectors[i].do_write) applyStimulus(0, vectors[i].wr_sel, vectors[i].wr_data);
            else tick();
            read_reg(0, vectors[i].rd_sel, vectors[i].do_read, rv);
            checkOutput($sformatf("vec%0d_do", i), {16'd0, rv}, {16'd0, vectors[i].exp_do});
            check_int(0, vectors[i].exp_int, $sformatf("vec%0d_int", i));
        end

        $display("[TB] basic count PERIOD=2");
        applyStimulus(0, R_PER, 16'd2);
        applyStimulus(0, R_CTRL, 16'h0003);
        check_reg(0, R_CNT, 16'd2, "start_cnt");
        check_int(0, 1'b0, "start_int");
        ticks(14);
        check_reg(0, R_CNT, 16'd2, "pre_dec_cnt");
        tick();
        check_reg(0, R_CNT, 16'd1, "dec_cnt");
        ticks(14);
        check_reg(0, R_CNT, 16'd1, "pre_exp_cnt");
        check_int(0, 1'b0, "pre_exp_int");
        tick();
        check_int(0, 1'b1, "exp_int");
        check_reg(0, R_CNT, 16'd2, "exp_reload");
        check_reg(0, R_CTRL, 16'h0007, "exp_ctrl");

        $display("[TB] ST write rules");
        applyStimulus(0, R_CTRL, 16'h0007);
        check_reg(0, R_CTRL, 16'h0007, "st_keep_ctrl");
        check_int(0, 1'b1, "st_keep_int");
        applyStimulus(0, R_CTRL, 16'h0003);
        check_reg(0, R_CTRL, 16'h0003, "st_clr_ctrl");
        check_int(0, 1'b0, "st_clr_int");
        ticks(12);
        check_reg(0, R_CNT, 16'd2, "cont_cnt2");
        tick();
        check_reg(0, R_CNT, 16'd1, "cont_cnt1");

        $display("[TB] ST clear on expiry cycle");
        ticks(14);
        check_reg(0, R_CTRL, 16'h0003, "race_pre_ctrl");
        applyStimulus(0, R_CTRL, 16'h0003);
        check_reg(0, R_CTRL, 16'h0007, "race_set_wins");
        check_int(0, 1'b1, "race_set_int");
        check_reg(0, R_CNT, 16'd2, "race_reload");

        $display("[TB] EN=0 on expiry cycle");
        applyStimulus(0, R_CTRL, 16'h0000);
        check_reg(0, R_CTRL, 16'h0000, "stop_ctrl");
        check_reg(0, R_CNT, 16'd2, "stop_cnt");
        applyStimulus(0, R_CTRL, 16'h0003);
        ticks(29);
        check_reg(0, R_CNT, 16'd1, "en0_pre_cnt");
        applyStimulus(0, R_CTRL, 16'h0002);
        check_reg(0, R_CNT, 16'd1, "en0_hold_cnt");
        check_reg(0, R_CTRL, 16'h0002, "en0_ctrl");
        check_int(0, 1'b0, "en0_int");
        ticks(20);
        check_reg(0, R_CNT, 16'd1, "en0_frozen");

        $display("[TB] IE gating");
        applyStimulus(0, R_CTRL, 16'h0001);
        ticks(29);
        check_reg(0, R_CNT, 16'd1, "ie0_pre_cnt");
        tick();
        check_reg(0, R_CTRL, 16'h0005, "ie0_st_set");
        check_int(0, 1'b0, "ie0_int");
        applyStimulus(0, R_CTRL, 16'h0007);
        check_int(0, 1'b1, "ie1_int");
        applyStimulus(0, R_CTRL, 16'h0005);
        check_int(0, 1'b0, "ie_clr_int");
        check_reg(0, R_CTRL, 16'h0005, "ie_clr_keep_st");

        $display("[TB] CE gating of writes");
        CE = 1'b0;
        applyStimulus(0, R_PER, 16'h00FF);
        CE = 1'b1;
        check_reg(0, R_PER, 16'd2, "ce0_write_ignored");

        $display("[TB] CE 1-in-3 duty");
        applyStimulus(0, R_CTRL, 16'h0000);
        applyStimulus(0, R_CTRL, 16'h0003);
        for (int k = 1; k <= 90; k++) begin
            CE = (k % 3 == 0);
            tick();
            if (k == 44) check_reg(0, R_CNT, 16'd2, "duty_cnt_k44");
            if (k == 45) check_reg(0, R_CNT, 16'd1, "duty_cnt_k45");
            if (k == 89) check_int(0, 1'b0, "duty_int_k89");
        end
        CE = 1'b1;
        check_int(0, 1'b1, "duty_int_k90");
        check_reg(0, R_CNT, 16'd2, "duty_reload");

        $display("[TB] reset mid-count");
        ticks(7);
        CE = 1'b0;
        #2;
        RESn = 1'b0;
        #1;
        check_reg(0, R_CNT, 16'd0, "arst_cnt");
        check_reg(0, R_CTRL, 16'h0000, "arst_ctrl");
        check_reg(0, R_PER, 16'h0000, "arst_period");
        check_int(0, 1'b0, "arst_int");
        #2;
        RESn = 1'b1;
        CE   = 1'b1;
        ticks(40);
        check_reg(0, R_CNT, 16'd0, "post_rst_cnt");
        check_reg(0, R_CTRL, 16'h0000, "post_rst_ctrl");

        $display("[TB] PERIOD=0 full interval, PRESCALE=1");
        applyStimulus(1, R_PER, 16'd0);
        applyStimulus(1, R_CTRL, 16'h0001);
        check_reg(1, R_CNT, 16'h0000, "p0_start_cnt");
        tick();
        check_reg(1, R_CNT, 16'hFFFF, "p0_first_dec");
        ticks(65534);
        check_reg(1, R_CNT, 16'h0001, "p0_pre_exp_cnt");
        check_reg(1, R_CTRL, 16'h0001, "p0_pre_exp_ctrl");
        tick();
        check_reg(1, R_CTRL, 16'h0005, "p0_exp_ctrl");
        check_reg(1, R_CNT, 16'h0000, "p0_exp_reload");
        tick();
        check_reg(1, R_CNT, 16'hFFFF, "p0_post_exp_dec");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
